// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with a TX input FIFO and an oversampled RX.
// Word format (data bits, parity, stop bits) is fixed at build time.
// Optional feature macro: UART_LOOPBACK_EN adds a 'loopback' input that routes
// the internal TX stream into the RX path and parks the tx pin high.
module uart_fifo_core #(
   parameter int CLK_FREQ      = 100_000_000,
   parameter int BAUD_RATE     = 9_600,
   parameter int OVERSAMPLE    = 16,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 1,
   parameter int STOP_BITS     = 1,
   parameter int TX_FIFO_DEPTH = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_BITS-1:0]             din,
   input  logic                             din_vld,
   output logic                             rfd,
   output logic [$clog2(TX_FIFO_DEPTH):0]   tx_level,
   output logic                             tx_busy,
   output logic                             tx,
   input  logic                             rx,
   output logic [DATA_BITS-1:0]             dout,
   output logic                             dout_vld,
   output logic                             par_err,
`ifdef UART_LOOPBACK_EN
   input  logic                             loopback,
`endif
   output logic                             frm_err
);

   localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE) - 1;
   localparam int DIV_W = (DIV > 0) ? $clog2(DIV + 1) : 1;
   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int AW    = $clog2(TX_FIFO_DEPTH);
   localparam int LW    = AW + 1;

   localparam logic [DIV_W-1:0] DIV_V     = DIV_W'(DIV);
   localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic [LW-1:0]    FULL_LVL  = LW'(TX_FIFO_DEPTH);
   localparam logic             HAS_PAR   = (PARITY != 0);
   localparam logic             ODD_PAR   = (PARITY == 2);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

   localparam logic [2:0] TX_IDLE  = 3'd0;
   localparam logic [2:0] TX_START = 3'd1;
   localparam logic [2:0] TX_DATA  = 3'd2;
   localparam logic [2:0] TX_PAR   = 3'd3;
   localparam logic [2:0] TX_STOP  = 3'd4;

   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_PAR   = 3'd3;
   localparam logic [2:0] RX_STOP  = 3'd4;
   localparam logic [2:0] RX_BREAK = 3'd5;

   // ---------------------------------------------------------------------
   // Oversample tick
   // ---------------------------------------------------------------------
   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   assign tick = (div_cnt == '0);

   // Free-running down-counter; one-cycle tick each time it hits zero
   always_ff @(posedge clk) begin
      if (rst || tick) div_cnt <= DIV_V;
      else             div_cnt <= div_cnt - 1'b1;
   end

   // ---------------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------------
   logic [DATA_BITS-1:0] mem [TX_FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [LW-1:0]        level;
   logic                 push, pop, fifo_nempty;
   logic [DATA_BITS-1:0] fifo_rdata;

   // rfd gates push, so a push while full is dropped even if a pop happens too
   assign rfd         = (level != FULL_LVL);
   assign push        = din_vld && rfd;
   assign fifo_nempty = (level != '0);
   assign fifo_rdata  = mem[rd_ptr];
   assign tx_level    = level;

   // Storage array has no reset; only the pointers define content validity
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // TX FSM
   // ---------------------------------------------------------------------
   logic [2:0]           tx_state;
   logic [OS_W-1:0]      tx_tcnt;
   logic [3:0]           tx_bit;
   logic                 tx_sidx;
   logic [DATA_BITS-1:0] tx_sh;
   logic                 tx_par;
   logic                 tx_bit_end;
   logic                 tx_line;

   assign tx_bit_end = tick && (tx_tcnt == OS_LAST);
   assign tx_busy    = (tx_state != TX_IDLE);

   // Pop on the first tick out of IDLE, or at the end of the last stop bit so
   // back-to-back words go out with no idle gap
   always_comb begin
      pop = 1'b0;
      if (tick && fifo_nempty) begin
         if (tx_state == TX_IDLE)
            pop = 1'b1;
         else if (tx_state == TX_STOP && tx_tcnt == OS_LAST && tx_sidx == LAST_STOP)
            pop = 1'b1;
      end
   end

   // Frame sequencer: every line bit spans OVERSAMPLE ticks
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_tcnt  <= '0;
         tx_bit   <= '0;
         tx_sidx  <= 1'b0;
         tx_sh    <= '0;
         tx_par   <= 1'b0;
      end else begin
         if (tx_state != TX_IDLE && tick)
            tx_tcnt <= (tx_tcnt == OS_LAST) ? '0 : tx_tcnt + 1'b1;
         if (pop) begin
            tx_sh  <= fifo_rdata;
            tx_par <= ^fifo_rdata ^ ODD_PAR;
         end
         case (tx_state)
            TX_IDLE: begin
               if (pop) tx_state <= TX_START;
            end
            TX_START: begin
               if (tx_bit_end) begin
                  tx_bit   <= '0;
                  tx_state <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (tx_bit_end) begin
                  tx_sh <= tx_sh >> 1;
                  if (tx_bit == LAST_BIT) begin
                     tx_sidx  <= 1'b0;
                     tx_state <= HAS_PAR ? TX_PAR : TX_STOP;
                  end else begin
                     tx_bit <= tx_bit + 1'b1;
                  end
               end
            end
            TX_PAR: begin
               if (tx_bit_end) begin
                  tx_sidx  <= 1'b0;
                  tx_state <= TX_STOP;
               end
            end
            TX_STOP: begin
               if (tx_bit_end) begin
                  if (tx_sidx == LAST_STOP) tx_state <= pop ? TX_START : TX_IDLE;
                  else                      tx_sidx  <= 1'b1;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // Line level decoded from the sequencer state; idle/stop are high
   always_comb begin
      tx_line = 1'b1;
      case (tx_state)
         TX_START: tx_line = 1'b0;
         TX_DATA:  tx_line = tx_sh[0];
         TX_PAR:   tx_line = tx_par;
         default:  tx_line = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------
   // Pin routing
   // ---------------------------------------------------------------------
   logic rx_src;

`ifdef UART_LOOPBACK_EN
   assign tx     = loopback ? 1'b1 : tx_line;
   assign rx_src = loopback ? tx_line : rx;
`else
   assign tx     = tx_line;
   assign rx_src = rx;
`endif

   // ---------------------------------------------------------------------
   // RX path
   // ---------------------------------------------------------------------
   logic [1:0]           rx_sync;
   logic                 rx_s, rx_prev;
   logic [2:0]           rx_state;
   logic [OS_W-1:0]      rx_tcnt;
   logic [3:0]           rx_bit;
   logic [DATA_BITS-1:0] rx_sh;
   logic                 rx_par;
   logic                 rx_sample;

   assign rx_s      = rx_sync[1];
   assign rx_sample = tick && (rx_tcnt == OS_LAST);

   // Two-flop synchroniser, reset to the idle (high) line level
   always_ff @(posedge clk) begin
      if (rst) rx_sync <= 2'b11;
      else     rx_sync <= {rx_sync[0], rx_src};
   end

   // Receiver: validate start at half-bit, then sample each bit mid-cell
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         rx_prev  <= 1'b1;
         rx_tcnt  <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
         rx_par   <= 1'b0;
         dout     <= '0;
         dout_vld <= 1'b0;
         par_err  <= 1'b0;
         frm_err  <= 1'b0;
      end else begin
         rx_prev  <= rx_s;
         dout_vld <= 1'b0;
         par_err  <= 1'b0;
         frm_err  <= 1'b0;
         if ((rx_state == RX_DATA || rx_state == RX_PAR || rx_state == RX_STOP) && tick)
            rx_tcnt <= (rx_tcnt == OS_LAST) ? '0 : rx_tcnt + 1'b1;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_s) begin
                  rx_tcnt  <= '0;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (tick) begin
                  if (rx_tcnt == OS_HALF) begin
                     rx_tcnt  <= '0;
                     rx_bit   <= '0;
                     rx_state <= rx_s ? RX_IDLE : RX_DATA;
                  end else begin
                     rx_tcnt <= rx_tcnt + 1'b1;
                  end
               end
            end
            RX_DATA: begin
               if (rx_sample) begin
                  rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
                  if (rx_bit == LAST_BIT) rx_state <= HAS_PAR ? RX_PAR : RX_STOP;
                  else                    rx_bit   <= rx_bit + 1'b1;
               end
            end
            RX_PAR: begin
               if (rx_sample) begin
                  rx_par   <= rx_s;
                  rx_state <= RX_STOP;
               end
            end
            RX_STOP: begin
               // Word is delivered even when flagged; only the first stop bit is checked
               if (rx_sample) begin
                  dout     <= rx_sh;
                  dout_vld <= 1'b1;
                  par_err  <= HAS_PAR && (rx_par != (^rx_sh ^ ODD_PAR));
                  frm_err  <= !rx_s;
                  rx_state <= rx_s ? RX_IDLE : RX_BREAK;
               end
            end
            RX_BREAK: begin
               // Hold off start detection until the line returns high
               if (rx_s) rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: directed + randomized checks of uart_fifo_core at
// 16 clk per bit, 8 data bits, even parity, 1 stop bit.
module tb_uart_fifo_core;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       din_vld;
   logic       rfd;
   logic [4:0] tx_level;
   logic       tx_busy;
   logic       tx;
   logic       rx;
   logic [7:0] dout;
   logic       dout_vld;
   logic       par_err;
   logic       frm_err;
`ifdef UART_LOOPBACK_EN
   logic       loopback;
`endif

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   uart_fifo_core #(
      .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16)
   ) dut (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .rfd(rfd),
      .tx_level(tx_level), .tx_busy(tx_busy), .tx(tx), .rx(rx),
      .dout(dout), .dout_vld(dout_vld), .par_err(par_err),
`ifdef UART_LOOPBACK_EN
      .loopback(loopback),
`endif
      .frm_err(frm_err)
   );

   // Received-word log {frm_err, par_err, dout} and tx-pin activity flag
   logic [9:0] rx_q[$];
   bit         tx_low_seen = 1'b0;
   always @(negedge clk) begin
      if (dout_vld === 1'b1) rx_q.push_back({frm_err, par_err, dout});
      if (tx === 1'b0) tx_low_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference line frame, index 0 first on the wire: start, data LSB first, even parity, stop
   function automatic logic [10:0] frame(input logic [7:0] w);
      return {1'b1, ^w, w, 1'b0};
   endfunction

   // Wait for a start bit then sample every bit at its centre
   task automatic capture(output logic [10:0] fr, output int gap);
      gap = 0;
      fr  = '1;
      while (tx !== 1'b0 && gap < 4000) begin
         @(negedge clk);
         gap++;
      end
      if (gap >= 4000) chk("tx_start_timeout", 32'(tx), 0);
      else begin
         for (int i = 0; i < 11; i++) begin
            repeat (i == 0 ? 8 : 16) @(negedge clk);
            fr[i] = tx;
         end
      end
   endtask

   task automatic send_rx(input logic [7:0] w, input bit flip_par, input bit stop_val,
                          input int hold_bits);
      logic [10:0] f;
      f     = frame(w);
      f[9]  = f[9] ^ flip_par;
      f[10] = stop_val;
      for (int i = 0; i < 11; i++) begin
         rx = f[i];
         repeat (16) @(negedge clk);
      end
      repeat (hold_bits * 16) @(negedge clk);
      rx = 1'b1;
      repeat (32) @(negedge clk);
   endtask

   task automatic push_word(input logic [7:0] w);
      din     = w;
      din_vld = 1'b1;
      @(negedge clk);
      din_vld = 1'b0;
   endtask

   task automatic chk_rx(input string tag, input logic [9:0] exp);
      chk({tag, "_count"}, 32'(rx_q.size()), 1);
      if (rx_q.size() > 0) chk(tag, 32'(rx_q.pop_front()), 32'(exp));
      rx_q.delete();
   endtask

   logic [7:0]  words [20];
   logic [10:0] fr;
   int          gap;
   int          k;
   bit          first_full;

   initial begin
      rst = 1'b1; din = '0; din_vld = 1'b0; rx = 1'b1;
`ifdef UART_LOOPBACK_EN
      loopback = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 1);
      chk("rst_rfd", 32'(rfd), 1);
      chk("rst_level", 32'(tx_level), 0);
      chk("rst_busy", 32'(tx_busy), 0);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_vld", 32'(dout_vld), 0);
      chk("rst_perr", 32'(par_err), 0);
      chk("rst_ferr", 32'(frm_err), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single word 0xA5 and busy timing around the 176-clk frame end
      push_word(8'hA5);
      capture(fr, gap);
      chk("t1_frame", 32'(fr), 32'(frame(8'hA5)));
      repeat (6) @(negedge clk);
      chk("t1_busy_in_stop", 32'(tx_busy), 1);
      repeat (3) @(negedge clk);
      chk("t1_busy_after", 32'(tx_busy), 0);
      repeat (20) @(negedge clk);

      // Burst of 20 random words with din_vld held; frames must be contiguous
      foreach (words[i]) words[i] = 8'($urandom_range(0, 255));
      k = 0;
      first_full = 1'b1;
      fork
         begin
            int guard = 0;
            while (k < 20 && guard < 10000) begin
               bit acc;
               din     = words[k];
               din_vld = 1'b1;
               if (!rfd && first_full) begin
                  chk("t2_full_level", 32'(tx_level), 16);
                  first_full = 1'b0;
               end
               acc = rfd;
               @(negedge clk);
               guard++;
               if (acc) k++;
            end
            din_vld = 1'b0;
         end
         begin
            for (int i = 0; i < 20; i++) begin
               logic [10:0] f2;
               int g2;
               capture(f2, g2);
               chk($sformatf("t2_frame%0d", i), 32'(f2), 32'(frame(words[i])));
               if (i > 0) chk($sformatf("t2_gap%0d", i), 32'(g2), 8);
            end
         end
      join
      chk("t2_accepted", 32'(k), 20);
      chk("t2_rfd_dropped", 32'(first_full), 0);
      repeat (30) @(negedge clk);
      chk("t2_idle_busy", 32'(tx_busy), 0);
      chk("t2_idle_level", 32'(tx_level), 0);

      // RX: 0x3C then random words, all clean
      rx_q.delete();
      send_rx(8'h3C, 1'b0, 1'b1, 0);
      chk_rx("t3_rx_3c", {2'b00, 8'h3C});
      for (int i = 0; i < 5; i++) begin
         logic [7:0] w;
         w = 8'($urandom_range(0, 255));
         send_rx(w, 1'b0, 1'b1, 0);
         chk_rx("t3_rx_rand", {2'b00, w});
      end

      // Parity error: word still delivered with par_err
      send_rx(8'h3C, 1'b1, 1'b1, 0);
      chk_rx("t4_par_err", {2'b01, 8'h3C});
      begin
         logic [7:0] w;
         w = 8'($urandom_range(0, 255));
         send_rx(w, 1'b1, 1'b1, 0);
         chk_rx("t4_par_err_rand", {2'b01, w});
      end

      // Framing error followed by a 40-bit-time break: one delivery only
      send_rx(8'h3C, 1'b0, 1'b0, 40);
      chk_rx("t4_frm_err", {2'b10, 8'h3C});
      send_rx(8'hC3, 1'b0, 1'b1, 0);
      chk_rx("t4_after_break", {2'b00, 8'hC3});

      // 5-clk glitch is a false start
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (64) @(negedge clk);
      chk("t5_false_start", 32'(rx_q.size()), 0);

      // Reset in the middle of a TX frame
      push_word(8'h81);
      push_word(8'h7E);
      for (int g = 0; g < 100 && !tx_busy; g++) @(negedge clk);
      repeat (60) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_tx", 32'(tx), 1);
      chk("t5_rst_level", 32'(tx_level), 0);
      chk("t5_rst_busy", 32'(tx_busy), 0);
      rst = 1'b0;
      tx_low_seen = 1'b0;
      repeat (400) @(negedge clk);
      chk("t5_no_resume", 32'(tx_low_seen), 0);

`ifdef UART_LOOPBACK_EN
      // Loopback: words come back on dout, pin stays high, rx pin ignored
      loopback = 1'b1;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx_q.delete();
      tx_low_seen = 1'b0;
      push_word(8'h00);
      push_word(8'hFF);
      push_word(8'h5A);
      for (int g = 0; g < 1000 && rx_q.size() < 3; g++) @(negedge clk);
      chk("t6_count", 32'(rx_q.size()), 3);
      if (rx_q.size() == 3) begin
         chk("t6_w0", 32'(rx_q[0]), 32'({2'b00, 8'h00}));
         chk("t6_w1", 32'(rx_q[1]), 32'({2'b00, 8'hFF}));
         chk("t6_w2", 32'(rx_q[2]), 32'({2'b00, 8'h5A}));
      end
      chk("t6_pin_idle", 32'(tx_low_seen), 0);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      loopback = 1'b0;
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
